// File: rtl/pfi_word_packer_if.sv
// FIFO pop port and packed-word output port of the 6-bit-symbol word packer.
// master = packer side, slave = FIFO/downstream side.
interface pfi_word_packer_if;
    logic        o_pop_permit;
    logic [3:0]  o_pop_amount;
    logic        i_pop_enable;
    logic [95:0] i_pop_data;
    logic        o_word_valid;
    logic        i_word_ready;
    logic [95:0] o_word_data;
    logic [4:0]  o_word_symbols;
    logic        o_word_last;

    modport master (
        output o_pop_permit, o_pop_amount, o_word_valid, o_word_data, o_word_symbols, o_word_last,
        input  i_pop_enable, i_pop_data, i_word_ready
    );

    modport slave (
        input  o_pop_permit, o_pop_amount, o_word_valid, o_word_data, o_word_symbols, o_word_last,
        output i_pop_enable, i_pop_data, i_word_ready
    );
endinterface

// File: rtl/pfi_word_packer.sv
// Pulls variable-size 6-bit symbol groups from a FIFO and packs them into
// 96-bit words of 16 symbols, framed by a programmed symbol count.
module pfi_word_packer #(
    parameter int MAX_POP = 16,
    parameter int LEN_W   = 12
) (
    input  logic             i_core_clk,
    input  logic             i_rx_rst,
    input  logic             i_frame_start,
    input  logic [LEN_W-1:0] i_frame_len,
    output logic             o_busy,
    pfi_word_packer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [4:0] C_MAX_POP = 5'(MAX_POP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [4:0]       r_fill;
    logic [95:0]      r_acc;
    logic             r_word_valid;
    logic [95:0]      r_word_data;
    logic [4:0]       r_word_symbols;
    logic             r_word_last;

    logic [4:0]       w_space;
    logic [4:0]       w_n;
    logic [4:0]       w_fill_new;
    logic [LEN_W-1:0] w_rem_new;
    logic [95:0]      w_acc_new;
    logic             w_accept;
    logic             w_pop_fire;
    logic             w_complete;
    logic             w_handshake;

    assign w_accept    = (r_state == ST_IDLE) && i_frame_start && (i_frame_len != {LEN_W{1'b0}});
    assign w_pop_fire  = (r_state == ST_FILL) && bus.i_pop_enable;
    assign w_handshake = r_word_valid && bus.i_word_ready;
    assign w_fill_new  = r_fill + w_n;
    assign w_rem_new   = r_remaining - LEN_W'(w_n);
    assign w_complete  = (w_fill_new == 5'd16) || (w_rem_new == {LEN_W{1'b0}});

    // Pop size n = min(MAX_POP, 16 - fill, remaining)
    always_comb begin
        w_space = 5'd16 - r_fill;
        if (w_space < C_MAX_POP) begin
            w_n = w_space;
        end else begin
            w_n = C_MAX_POP;
        end
        if (LEN_W'(w_n) > r_remaining) begin
            w_n = r_remaining[4:0];
        end else begin
            w_n = w_n;
        end
    end

    // Merge the popped group: oldest symbol sits in the highest populated input slot
    always_comb begin
        w_acc_new = r_acc;
        for (int s = 0; s < 16; s++) begin
            if ((s >= int'(r_fill)) && (s < int'(r_fill) + int'(w_n))) begin
                w_acc_new[s*6 +: 6] = bus.i_pop_data[(int'(r_fill) + int'(w_n) - 1 - s)*6 +: 6];
            end else begin
                w_acc_new[s*6 +: 6] = r_acc[s*6 +: 6];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_FILL;
                else          w_state_nxt = ST_IDLE;
            end
            ST_FILL: begin
                if (w_pop_fire && w_complete) w_state_nxt = ST_HOLD;
                else                          w_state_nxt = ST_FILL;
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    if (r_remaining != {LEN_W{1'b0}}) w_state_nxt = ST_FILL;
                    else                              w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, accumulator and output word registers
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_state        <= ST_IDLE;
            r_remaining    <= {LEN_W{1'b0}};
            r_fill         <= 5'd0;
            r_acc          <= 96'd0;
            r_word_valid   <= 1'b0;
            r_word_data    <= 96'd0;
            r_word_symbols <= 5'd0;
            r_word_last    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_remaining <= i_frame_len;
            end else if (w_pop_fire) begin
                r_remaining <= w_rem_new;
            end else begin
                r_remaining <= r_remaining;
            end
            if (w_pop_fire && w_complete) begin
                r_fill         <= 5'd0;
                r_acc          <= 96'd0;
                r_word_valid   <= 1'b1;
                r_word_data    <= w_acc_new;
                r_word_symbols <= w_fill_new;
                r_word_last    <= (w_rem_new == {LEN_W{1'b0}});
            end else if (w_pop_fire) begin
                r_fill <= w_fill_new;
                r_acc  <= w_acc_new;
            end else if (w_handshake) begin
                r_word_valid <= 1'b0;
            end else begin
                r_word_valid <= r_word_valid;
            end
        end
    end

    assign o_busy             = (r_state != ST_IDLE);
    assign bus.o_pop_permit   = (r_state == ST_FILL);
    assign bus.o_pop_amount   = (r_state == ST_FILL) ? 4'(w_n - 5'd1) : 4'd0;
    assign bus.o_word_valid   = r_word_valid;
    assign bus.o_word_data    = r_word_data;
    assign bus.o_word_symbols = r_word_symbols;
    assign bus.o_word_last    = r_word_last;
endmodule

// File: tb/tb_pfi_word_packer.sv
// Bench for pfi_word_packer: three instances (MAX_POP 16, 5, 8) each fed by a
// model FIFO; words and pops are compared against a frame-level reference.
module tb_pfi_word_packer;
    localparam int NI    = 3;
    localparam int LEN_W = 12;
    localparam int FD    = 512;
    localparam int LG    = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst      [NI];
    logic             start    [NI];
    logic [LEN_W-1:0] flen     [NI];
    logic             busy     [NI];
    logic             ready    [NI];
    logic             permit   [NI];
    logic [3:0]       amt      [NI];
    logic             pop_en   [NI];
    logic [95:0]      pop_data [NI];
    logic             valid    [NI];
    logic [95:0]      wdata    [NI];
    logic [4:0]       wsym     [NI];
    logic             wlast    [NI];

    logic [5:0]  fmem    [NI][0:FD-1];
    int          fwr     [NI];
    int          frd     [NI];
    logic [3:0]  pop_log [NI][0:LG-1];
    logic [95:0] wd_log  [NI][0:LG-1];
    logic [4:0]  ws_log  [NI][0:LG-1];
    logic        wl_log  [NI][0:LG-1];
    int          pcnt    [NI];
    int          wcnt    [NI];

    int n_checks = 0;
    int n_fail   = 0;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int P = (g == 0) ? 16 : ((g == 1) ? 5 : 8);
            pfi_word_packer_if u_if ();
            assign u_if.i_pop_enable = pop_en[g];
            assign u_if.i_pop_data   = pop_data[g];
            assign u_if.i_word_ready = ready[g];
            assign permit[g] = u_if.o_pop_permit;
            assign amt[g]    = u_if.o_pop_amount;
            assign valid[g]  = u_if.o_word_valid;
            assign wdata[g]  = u_if.o_word_data;
            assign wsym[g]   = u_if.o_word_symbols;
            assign wlast[g]  = u_if.o_word_last;
            pfi_word_packer #(.MAX_POP(P), .LEN_W(LEN_W)) u_dut (
                .i_core_clk    (clk),
                .i_rx_rst      (rst[g]),
                .i_frame_start (start[g]),
                .i_frame_len   (flen[g]),
                .o_busy        (busy[g]),
                .bus           (u_if)
            );
        end
    endgenerate

    function automatic int mp_of(input int g);
        case (g)
            0:       return 16;
            1:       return 5;
            default: return 8;
        endcase
    endfunction

    // FIFO model: grants a pop only when it holds the requested symbol count
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            pop_en[i]   = permit[i] && ((fwr[i] - frd[i]) >= (int'(amt[i]) + 1));
            pop_data[i] = '0;
            for (int k = 0; k < 16; k++) begin
                if (k <= int'(amt[i]))
                    pop_data[i][(int'(amt[i]) - k)*6 +: 6] = fmem[i][(frd[i] + k) % FD];
            end
        end
    end

    // Record every pop and every accepted word
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (permit[i] && pop_en[i] && !rst[i]) begin
                frd[i]                   <= frd[i] + int'(amt[i]) + 1;
                pop_log[i][pcnt[i] % LG] <= amt[i];
                pcnt[i]                  <= pcnt[i] + 1;
            end
            if (valid[i] && ready[i] && !rst[i]) begin
                wd_log[i][wcnt[i] % LG] <= wdata[i];
                ws_log[i][wcnt[i] % LG] <= wsym[i];
                wl_log[i][wcnt[i] % LG] <= wlast[i];
                wcnt[i]                 <= wcnt[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int g, input logic [5:0] s);
        fmem[g][fwr[g] % FD] = s;
        fwr[g] = fwr[g] + 1;
    endtask

    task automatic check_idle_outputs(input int g, input string tag);
        check_eq({tag, "_ctl"}, {busy[g], permit[g], valid[g], wlast[g], amt[g]}, 96'd0);
        check_eq({tag, "_data"}, wdata[g], 96'd0);
        check_eq({tag, "_sym"}, 96'(wsym[g]), 96'd0);
    endtask

    // Runs a whole frame of random symbols and checks pops and words against the frame rules
    task automatic run_frame(input int g, input int len, input bit rand_ready);
        logic [5:0]  syms[$];
        logic [5:0]  s;
        logic [95:0] ew;
        int p0, w0, t, fill, rem, n, np, nw, left;
        p0 = pcnt[g];
        w0 = wcnt[g];
        for (int i = 0; i < len; i++) begin
            s = 6'($urandom_range(0, 63));
            syms.push_back(s);
            push(g, s);
        end
        @(negedge clk);
        flen[g]  = LEN_W'(len);
        start[g] = 1'b1;
        ready[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        t = 0;
        while (busy[g] && t < 3000) begin
            if (rand_ready) ready[g] = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        ready[g] = 1'b1;
        check_eq($sformatf("frame_end_g%0d_len%0d", g, len), 96'(busy[g]), 96'd0);
        fill = 0;
        rem  = len;
        np   = 0;
        while (rem > 0) begin
            n = mp_of(g);
            if (16 - fill < n) n = 16 - fill;
            if (rem < n) n = rem;
            check_eq($sformatf("pop%0d_g%0d_len%0d", np, g, len), 96'(pop_log[g][(p0 + np) % LG]), 96'(n - 1));
            np++;
            fill = (fill + n) % 16;
            rem  = rem - n;
        end
        check_eq($sformatf("pop_count_g%0d_len%0d", g, len), 96'(pcnt[g] - p0), 96'(np));
        nw = (len + 15) / 16;
        check_eq($sformatf("word_count_g%0d_len%0d", g, len), 96'(wcnt[g] - w0), 96'(nw));
        for (int w = 0; w < nw; w++) begin
            ew   = '0;
            left = len - 16 * w;
            for (int k = 0; k < 16; k++)
                if (k < left) ew[k*6 +: 6] = syms[16*w + k];
            check_eq($sformatf("wdata%0d_g%0d_len%0d", w, g, len), wd_log[g][(w0 + w) % LG], ew);
            check_eq($sformatf("wsym%0d_g%0d_len%0d", w, g, len), 96'(ws_log[g][(w0 + w) % LG]),
                     96'((left > 16) ? 16 : left));
            check_eq($sformatf("wlast%0d_g%0d_len%0d", w, g, len), 96'(wl_log[g][(w0 + w) % LG]),
                     96'(w == nw - 1));
        end
    endtask

    initial begin
        logic [95:0] ew;
        logic [5:0]  s;
        int          p0;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; flen[i] = '0; ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle_outputs(i, $sformatf("reset%0d", i));
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);

        // Single full word with symbols 0..15, exact cycle timing
        ew = '0;
        for (int k = 0; k < 16; k++) begin
            push(0, 6'(k));
            ew[k*6 +: 6] = 6'(k);
        end
        flen[0] = 12'd16; start[0] = 1'b1; ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check_eq("t1_permit", 96'(permit[0]), 96'd1);
        check_eq("t1_amount", 96'(amt[0]), 96'd15);
        check_eq("t1_busy", 96'(busy[0]), 96'd1);
        @(negedge clk);
        check_eq("t1_valid", 96'(valid[0]), 96'd1);
        check_eq("t1_data", wdata[0], ew);
        check_eq("t1_sym", 96'(wsym[0]), 96'd16);
        check_eq("t1_last", 96'(wlast[0]), 96'd1);
        check_eq("t1_permit_hold", 96'(permit[0]), 96'd0);
        @(negedge clk);
        check_eq("t1_busy_end", 96'(busy[0]), 96'd0);
        check_eq("t1_valid_end", 96'(valid[0]), 96'd0);

        run_frame(0, 20, 1'b0);
        run_frame(1, 16, 1'b0);

        // Underrun: only 3 symbols while 16 are requested, then backpressure
        ew = '0;
        for (int k = 0; k < 16; k++) begin
            s = 6'($urandom_range(0, 63));
            ew[k*6 +: 6] = s;
            if (k < 3) push(0, s);
        end
        flen[0] = 12'd16; start[0] = 1'b1; ready[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        p0 = pcnt[0];
        repeat (5) @(negedge clk);
        check_eq("t4_permit_underrun", 96'(permit[0]), 96'd1);
        check_eq("t4_no_pop_underrun", 96'(pcnt[0] - p0), 96'd0);
        for (int k = 3; k < 16; k++) push(0, ew[k*6 +: 6]);
        @(negedge clk);
        check_eq("t4_valid", 96'(valid[0]), 96'd1);
        flen[0] = 12'd100; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        p0 = pcnt[0];
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("t4_hold_valid%0d", c), 96'(valid[0]), 96'd1);
            check_eq($sformatf("t4_hold_data%0d", c), wdata[0], ew);
            check_eq($sformatf("t4_hold_meta%0d", c), {wsym[0], wlast[0], permit[0]}, {5'd16, 1'b1, 1'b0});
            @(negedge clk);
        end
        check_eq("t4_no_pop_hold", 96'(pcnt[0] - p0), 96'd0);
        ready[0] = 1'b1;
        @(negedge clk);
        check_eq("t4_busy_after_ignored_start", 96'(busy[0]), 96'd0);
        check_eq("t4_valid_end", 96'(valid[0]), 96'd0);

        // Zero-length start is ignored
        flen[0] = 12'd0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check_eq("t5_zero_len_busy", 96'(busy[0]), 96'd0);
        check_eq("t5_zero_len_permit", 96'(permit[0]), 96'd0);

        // Reset mid-frame with fill = 8 on the MAX_POP=8 instance
        for (int k = 0; k < 8; k++) push(2, 6'($urandom_range(0, 63)));
        p0 = pcnt[2];
        flen[2] = 12'd16; start[2] = 1'b1; ready[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        @(negedge clk);
        check_eq("t6_one_pop", 96'(pcnt[2] - p0), 96'd1);
        check_eq("t6_still_filling", 96'(permit[2]), 96'd1);
        rst[2] = 1'b1;
        @(negedge clk);
        check_idle_outputs(2, "t6_mid_reset");
        rst[2] = 1'b0;
        run_frame(2, 16, 1'b0);

        // Randomized frames across all three pop sizes
        for (int r = 0; r < 12; r++)
            run_frame($urandom_range(0, NI - 1), $urandom_range(1, 60), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
